// File: rtl/bank_sched_pkg.sv
// -----------------------------------------------------------------------------
// bank_sched_pkg
// Shared definitions for the per-bank-group scheduler and its round-robin
// picker: scheduler state encoding, default parameter values and the helper
// that sizes bank index fields.
// -----------------------------------------------------------------------------
package bank_sched_pkg;

    // Scheduler states: waiting for a turn, serving one bank, enforcing the
    // same-group command gap.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int DEF_NUM_BANKS = 4;
    localparam int DEF_TCCD      = 4;
    localparam int DEF_MAX_BURST = 4;
    localparam int DEF_AGE_LIMIT = 16;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bank_sched_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational masked priority encoder. Returns the first set request bit at
// or above the pointer, wrapping to the lowest set bit when none is found
// above it. Also used by the group-level arbiter.
//
// Ports:
//   req_i   [N-1:0]  request vector
//   ptr_i   [W-1:0]  round-robin start position
//   valid_o          at least one request bit set
//   idx_o   [W-1:0]  winning index (0 when valid_o is low)
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         valid_o,
    output logic [W-1:0] idx_o
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] hi_req;

    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign hi_mask[gi] = (ptr_i <= W'(gi));
    end

    assign hi_req = req_i & hi_mask;

    // Descending loops so the lowest set index is the last write. The masked
    // scan runs second, so any request at or above the pointer overrides the
    // wrapped (unmasked) choice.
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = W'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (hi_req[i]) idx_o = W'(i);
        end
    end

endmodule

// File: rtl/bank_sched.sv
// -----------------------------------------------------------------------------
// bank_sched
// Per-bank-group scheduler below the group FSM. On a granted turn it serves
// the group's banks in round-robin order (level start, one-cycle done),
// keeps TCCD cycles between a done and the next start, caps grants per turn
// at MAX_BURST and returns the turn with a one-cycle grp_done_o pulse.
//
// Optional build macro: BANK_AGE_PRIORITY_EN -- per-bank saturating age
// counters; a bank whose age reaches AGE_LIMIT wins the next selection
// (lowest such index). Without it selection is pure round-robin.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   grp_start_i       turn granted by the group FSM, sampled in IDLE only
//   req_i   [NB-1:0]  per-bank pending request
//   done_i  [NB-1:0]  per-bank one-cycle completion pulse
//   start_o [NB-1:0]  one-hot start, held while the bank is served
//   bank_sel_o        index of the served bank, valid while busy_o
//   busy_o            high in SERVE and GAP
//   grp_done_o        one-cycle pulse when the turn is released
// -----------------------------------------------------------------------------
module bank_sched
    import bank_sched_pkg::*;
#(
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int TCCD      = DEF_TCCD,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int AGE_LIMIT = DEF_AGE_LIMIT
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             grp_start_i,
    input  logic [NUM_BANKS-1:0]             req_i,
    input  logic [NUM_BANKS-1:0]             done_i,
    output logic [NUM_BANKS-1:0]             start_o,
    output logic [idx_width(NUM_BANKS)-1:0]  bank_sel_o,
    output logic                             busy_o,
    output logic                             grp_done_o
);

    localparam int SW = idx_width(NUM_BANKS);
    localparam int GW = idx_width(TCCD);
    localparam int BW = $clog2(MAX_BURST + 1);

    if (NUM_BANKS < 2 || NUM_BANKS > 8 || (NUM_BANKS & (NUM_BANKS - 1)) != 0 ||
        TCCD < 1 || MAX_BURST < 1 || AGE_LIMIT < 1) begin : g_param_check
        $error("bank_sched: illegal parameter set");
    end

    state_e               state_q, state_d;
    logic [SW-1:0]        ptr_q, ptr_d;
    logic [BW-1:0]        burst_q, burst_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [SW-1:0]        bank_sel_q, bank_sel_d;
    logic [NUM_BANKS-1:0] start_q, start_d;
    logic                 busy_q, busy_d;
    logic                 grp_done_q, grp_done_d;

    logic                 pick_valid;
    logic [SW-1:0]        rr_idx;
    logic [SW-1:0]        pick_idx;
    logic                 grant;

    rr_picker #(
        .N (NUM_BANKS),
        .W (SW)
    ) u_rr (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (rr_idx)
    );

`ifdef BANK_AGE_PRIORITY_EN
    localparam int AW = $clog2(AGE_LIMIT + 1);

    logic [NUM_BANKS-1:0] aged;
    logic                 aged_valid;
    logic [SW-1:0]        aged_idx;

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_age
        logic [AW-1:0] age_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                age_q <= '0;
            end else if (!req_i[gi] || (grant && pick_idx == SW'(gi))) begin
                age_q <= '0;
            end else if (!(state_q == ST_SERVE && bank_sel_q == SW'(gi)) &&
                         age_q != AW'(AGE_LIMIT)) begin
                age_q <= age_q + AW'(1);
            end
        end

        assign aged[gi] = (age_q == AW'(AGE_LIMIT));
    end

    // Pointer fixed at 0: among starved banks the lowest index wins.
    rr_picker #(
        .N (NUM_BANKS),
        .W (SW)
    ) u_aged (
        .req_i   (aged),
        .ptr_i   ('0),
        .valid_o (aged_valid),
        .idx_o   (aged_idx)
    );

    assign pick_idx = aged_valid ? aged_idx : rr_idx;
`else
    assign pick_idx = rr_idx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            burst_q    <= '0;
            gap_q      <= '0;
            bank_sel_q <= '0;
            start_q    <= '0;
            busy_q     <= 1'b0;
            grp_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            burst_q    <= burst_d;
            gap_q      <= gap_d;
            bank_sel_q <= bank_sel_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            grp_done_q <= grp_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        burst_d    = burst_q;
        gap_d      = gap_q;
        bank_sel_d = bank_sel_q;
        start_d    = start_q;
        busy_d     = busy_q;
        grp_done_d = 1'b0;
        grant      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (grp_start_i) begin
                    if (pick_valid) begin
                        grant   = 1'b1;
                        burst_d = '0;
                    end else begin
                        // Turn offered with nothing to do: hand it straight back.
                        grp_done_d = 1'b1;
                    end
                end
            end
            ST_SERVE: begin
                // Only the served bank's done ends service; a dropped req does not.
                if (done_i[bank_sel_q]) begin
                    ptr_d   = bank_sel_q + SW'(1);
                    burst_d = burst_q + BW'(1);
                    gap_d   = GW'(TCCD - 1);
                    start_d = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end else if (pick_valid && burst_q < BW'(MAX_BURST)) begin
                    grant = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                    busy_d     = 1'b0;
                    grp_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                start_d = '0;
                busy_d  = 1'b0;
            end
        endcase

        if (grant) begin
            state_d    = ST_SERVE;
            bank_sel_d = pick_idx;
            start_d    = NUM_BANKS'(1) << pick_idx;
            busy_d     = 1'b1;
        end
    end

    assign start_o    = start_q;
    assign bank_sel_o = bank_sel_q;
    assign busy_o     = busy_q;
    assign grp_done_o = grp_done_q;

endmodule

// File: tb/tb_bank_sched.sv
// -----------------------------------------------------------------------------
// tb_bank_sched
// Table of group turns for the default instance (4 banks, TCCD=4,
// MAX_BURST=4). Each record gives the request pattern, how long each bank
// takes to answer done, whether banks keep requesting after service, a stray
// done mask, and the expected grant order. Expected grant/release cycles are
// queued when a turn is launched and popped by a monitor as the DUT reacts.
// Hand-written sequences cover reset state, reset during service and a second
// instance with MAX_BURST=2, TCCD=1.
// -----------------------------------------------------------------------------
module tb_bank_sched;

    localparam int TCCD = 4;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] serve;   // cycles start stays high before done
        logic       keep;    // bank keeps requesting after service
        logic [3:0] stray;   // done bits raised on other banks while serving
        logic [2:0] n;       // number of grants expected this turn
        logic [7:0] seq;     // grant j at seq[2j +: 2]
    } vec_t;

    typedef struct {
        int bank;
        int rise;
        int fall;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       grp_start = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] done = '0;
    logic [3:0] start;
    logic [1:0] bank_sel;
    logic       busy;
    logic       grp_done;

    logic       grp_start2 = 1'b0;
    logic [3:0] req2 = '0;
    logic [3:0] done2 = '0;
    logic [3:0] start2;
    logic [1:0] bank_sel2;
    logic       busy2;
    logic       grp_done2;

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    serve_len = 1;
    int    hold = 0;
    bit    keep = 1'b0;
    logic [3:0] stray = '0;
    string cur = "reset";

    exp_t  gq[$];
    int    dq[$];
    bit    pend = 1'b0;
    int    pend_fall = 0;
    logic [3:0] prev_start = '0;

    vec_t  tbl [9];

    bank_sched #(
        .NUM_BANKS (4), .TCCD (TCCD), .MAX_BURST (4), .AGE_LIMIT (16)
    ) u_dut (
        .clk (clk), .rst_n (rst_n), .grp_start_i (grp_start), .req_i (req),
        .done_i (done), .start_o (start), .bank_sel_o (bank_sel),
        .busy_o (busy), .grp_done_o (grp_done)
    );

    bank_sched #(
        .NUM_BANKS (4), .TCCD (1), .MAX_BURST (2), .AGE_LIMIT (16)
    ) u_dut2 (
        .clk (clk), .rst_n (rst_n), .grp_start_i (grp_start2), .req_i (req2),
        .done_i (done2), .start_o (start2), .bank_sel_o (bank_sel2),
        .busy_o (busy2), .grp_done_o (grp_done2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [%s] cyc=%0d: got %0h want %0h", nm, cur, cyc, act, exp);
        end
    endtask

    // Bank model: answers done after serve_len cycles of start, optionally
    // withdrawing its request, and raises stray done bits meanwhile.
    always @(negedge clk) begin
        if (!rst_n) begin
            done = '0;
            hold = 0;
        end else if (start != '0) begin
            if (hold + 1 == serve_len) begin
                done = start;
                hold = 0;
                if (!keep) req = req & ~start;
            end else begin
                done = stray;
                hold++;
            end
        end else begin
            done = '0;
            hold = 0;
        end
    end

    // Monitor: pops expectations as grants start, end and the turn is released.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            pend = 1'b0;
            prev_start = '0;
        end else begin
            if (start != '0 && prev_start == '0) begin
                if (gq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_grant [%s] cyc=%0d: got start %0h want none", cur, cyc, start);
                end else begin
                    e = gq.pop_front();
                    chk("grant_bank", 32'(bank_sel), 32'(e.bank));
                    chk("grant_onehot", 32'(start), 32'(1) << e.bank);
                    chk("grant_cycle", cyc, e.rise);
                    chk("busy_at_grant", 32'(busy), 1);
                    pend = 1'b1;
                    pend_fall = e.fall;
                end
            end
            if (start == '0 && prev_start != '0 && pend) begin
                chk("release_cycle", cyc, pend_fall);
                pend = 1'b0;
            end
            if (grp_done) begin
                if (dq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_grp_done [%s] cyc=%0d: got 1 want 0", cur, cyc);
                end else begin
                    chk("grp_done_cycle", cyc, dq.pop_front());
                    chk("busy_at_grp_done", 32'(busy), 0);
                end
            end
            prev_start = start;
        end
    end

    task automatic run_turn(input vec_t v, input string nm);
        int k;
        int t;
        int waited;
        @(negedge clk);
        cur = nm;
        req = v.req;
        serve_len = int'(v.serve);
        keep = v.keep;
        stray = v.stray;
        grp_start = 1'b1;
        k = cyc + 1;
        t = k;
        for (int j = 0; j < int'(v.n); j++) begin
            gq.push_back('{int'(v.seq[2*j +: 2]), t, t + int'(v.serve)});
            t = t + int'(v.serve) + TCCD;
        end
        dq.push_back(t);
        @(negedge clk);
        grp_start = 1'b0;
        waited = 0;
        while ((gq.size() != 0 || dq.size() != 0 || pend) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 300) begin
            total++;
            bad++;
            $display("FAIL turn_timeout [%s]: got %0d grants/%0d releases outstanding want 0", nm, gq.size(), dq.size());
            gq.delete();
            dq.delete();
        end
        req = '0;
        $display("turn %s done at cyc=%0d", nm, cyc);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int waited;

        //            req      serve  keep  stray    n     seq (j=3..0)
        tbl[0] = '{4'b1111, 4'd1, 1'b0, 4'b0000, 3'd4, {2'd3, 2'd2, 2'd1, 2'd0}};
        tbl[1] = '{4'b0100, 4'd3, 1'b0, 4'b0000, 3'd1, {2'd0, 2'd0, 2'd0, 2'd2}};
        tbl[2] = '{4'b1010, 4'd2, 1'b1, 4'b0000, 3'd4, {2'd1, 2'd3, 2'd1, 2'd3}};
        tbl[3] = '{4'b0000, 4'd1, 1'b0, 4'b0000, 3'd0, {2'd0, 2'd0, 2'd0, 2'd0}};
        tbl[4] = '{4'b0011, 4'd1, 1'b0, 4'b0000, 3'd2, {2'd0, 2'd0, 2'd1, 2'd0}};
        tbl[5] = '{4'b1111, 4'd2, 1'b1, 4'b0000, 3'd4, {2'd1, 2'd0, 2'd3, 2'd2}};
        tbl[6] = '{4'b1000, 4'd5, 1'b0, 4'b0001, 3'd1, {2'd0, 2'd0, 2'd0, 2'd3}};
        tbl[7] = '{4'b0001, 4'd1, 1'b0, 4'b0000, 3'd1, {2'd0, 2'd0, 2'd0, 2'd0}};
        tbl[8] = '{4'b0011, 4'd1, 1'b0, 4'b0000, 3'd2, {2'd0, 2'd0, 2'd1, 2'd0}};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_start", 32'(start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grp_done", 32'(grp_done), 0);
        chk("rst_bank_sel", 32'(bank_sel), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_turn(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of serving bank 2 (pointer is 1 beforehand)
        @(negedge clk);
        cur = "reset_mid_serve";
        req = 4'b0100;
        serve_len = 10;
        keep = 1'b0;
        stray = '0;
        grp_start = 1'b1;
        k = cyc + 1;
        gq.push_back('{2, k, k + 10});
        @(negedge clk);
        grp_start = 1'b0;
        waited = 0;
        while (gq.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("mid_serve_grant_seen", 32'(gq.size()), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        gq.delete();
        dq.delete();
        #1;
        chk("async_rst_start", 32'(start), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_grp_done", 32'(grp_done), 0);
        req = '0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        $display("turn reset_mid_serve done at cyc=%0d", cyc);
        // Pointer must be back at 0: bank 0 before bank 1
        run_turn(tbl[8], "post_reset");

        // Second instance: MAX_BURST=2, TCCD=1
        cur = "burst_cap";
        @(negedge clk);
        req2 = 4'b1111;
        grp_start2 = 1'b1;
        @(negedge clk);
        grp_start2 = 1'b0;
        chk("cap_grant0", 32'(start2), 32'h1);
        chk("cap_sel0", 32'(bank_sel2), 0);
        done2 = 4'b0001;
        @(negedge clk);
        done2 = '0;
        chk("cap_gap_start", 32'(start2), 0);
        chk("cap_gap_busy", 32'(busy2), 1);
        @(negedge clk);
        chk("cap_grant1", 32'(start2), 32'h2);
        chk("cap_sel1", 32'(bank_sel2), 1);
        done2 = 4'b0010;
        @(negedge clk);
        done2 = '0;
        @(negedge clk);
        chk("cap_grp_done", 32'(grp_done2), 1);
        chk("cap_busy_idle", 32'(busy2), 0);
        chk("cap_start_idle", 32'(start2), 0);
        grp_start2 = 1'b1;
        @(negedge clk);
        grp_start2 = 1'b0;
        chk("cap_grp_done_pulse", 32'(grp_done2), 0);
        chk("cap_next_turn", 32'(start2), 32'h4);
        chk("cap_next_sel", 32'(bank_sel2), 2);
        done2 = 4'b0100;
        @(negedge clk);
        done2 = '0;
        req2 = '0;
        $display("turn burst_cap done at cyc=%0d", cyc);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bank_sched.md
# bank_sched

Per-bank-group scheduler that sits below the bank-group FSM (`Groups_Fsm`). Once the group FSM hands this group a turn, it serves the group's banks in round-robin order with a level start / one-cycle done handshake. It enforces a minimum same-group command gap and caps the number of grants per turn. It then returns the turn with a one-cycle completion pulse.

## Interface
Parameters:
- NUM_BANKS, 4: banks in this group; must be a power of two, 2 to 8.
- TCCD, 4: gap cycles between one bank's done and the next start; must be 1 or more.
- MAX_BURST, 4: grants per group turn before the turn is released.
- AGE_LIMIT, 16: age threshold, used only with the feature in Configuration.

Ports (one clock; reset is asynchronous and active-low):
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- grp_start, in, 1: turn granted by the group FSM; sampled only in IDLE.
- req, in, NUM_BANKS: per-bank pending request; held by the bank until served.
- done, in, NUM_BANKS: per-bank one-cycle completion pulse.
- start, out, NUM_BANKS: one-hot start, held high while the bank is served.
- bank_sel, out, log2(NUM_BANKS): index of the bank being served; valid while busy.
- busy, out, 1: high in SERVE and GAP.
- grp_done, out, 1: one-cycle pulse when the turn is released.

## Operation
Reset values: all outputs 0, state IDLE, round-robin pointer 0, burst count 0, gap count 0.

States:
- IDLE:
  - If grp_start and any req bit are set, pick a winner, latch it into bank_sel, clear the burst count, go to SERVE.
  - If grp_start is set with no req bits, pulse grp_done and stay in IDLE.
- SERVE:
  - start[bank_sel] is high.
  - On done[bank_sel]: pointer becomes bank_sel+1 (mod NUM_BANKS), burst count increments, gap count loads TCCD-1, go to GAP.
  - done bits of other banks are ignored.
  - A req drop on the served bank does not end service; only done does.
- GAP:
  - Gap count decrements each cycle.
  - When it reaches 0 and the burst count is below MAX_BURST with any req bit set, pick a winner and go to SERVE.
  - Otherwise pulse grp_done and go to IDLE.

Selection:
- Round-robin picks the first req bit at or above the pointer, wrapping around.
- The bank just served is eligible again only after the others, because of the pointer advance.

Boundary conditions:
- done arriving in the same cycle start rises is legal; service completes that cycle.
- A req change in the same cycle as a winner decision uses the sampled value.
- Reset mid-operation drops start and busy immediately; no pending grp_done is emitted.

## Timing
- All outputs are registered.
- grp_start and req sampled at edge k: start and busy high after edge k.
- done sampled at edge m: start low after edge m.
  - Next start high after edge m+TCCD if requests remain.
  - Otherwise grp_done high for the single cycle after edge m+TCCD.
- Minimum period for one grant: 1 SERVE cycle plus TCCD GAP cycles.

## Configuration
- BANK_AGE_PRIORITY_EN defined:
  - Each bank has a saturating age counter; it increments each cycle req[i]=1 and the bank is not being served.
  - The counter clears when the bank is granted or req[i]=0.
  - At selection, any bank whose age equals AGE_LIMIT wins over round-robin; the lowest such index wins.
  - The pointer still advances past the served bank.
- BANK_AGE_PRIORITY_EN undefined: pure round-robin; no age counters are built.

## Structure
- Package bank_sched_pkg holds:
  - the state enum (IDLE, SERVE, GAP);
  - default parameter constants;
  - a function computing the bank index width.
- Sub-module rr_picker: combinational masked priority encoder taking req and pointer, returning valid and index. It is reused by the group-level arbiter.

## Test plan
- Single bank: req=4'b0100 with grp_start pulse, done after 3 cycles -> start=4'b0100 for 3 cycles, bank_sel=2, then TCCD=4 gap cycles, then grp_done pulse.
- All banks: req=4'b1111, each done after 1 cycle, MAX_BURST=4 -> grants in order 0,1,2,3, starts spaced by TCCD, grp_done after the 4th gap.
- Burst cap: req=4'b1111, MAX_BURST=2 -> grants 0 and 1 only; the next turn begins at bank 2.
- Stray done: done=4'b0001 while bank 3 is served -> no state change; start remains 4'b1000.
- Reset mid-SERVE: rst_n low for 1 cycle -> start=0, busy=0 immediately; after release, pointer=0 and no grp_done.
- With BANK_AGE_PRIORITY_EN, AGE_LIMIT=8: bank 3 starved past 8 cycles while banks 0 to 2 recycle -> bank 3 wins at the next decision regardless of pointer.
